// File: rtl/cache_port_arbiter_pkg.sv
// Shared types for the two-port cache arbiter: FSM state encoding and requester id width.
package cache_port_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int REQ_ID_W = 1;

    typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/cache_port_arbiter_rr_pick2.sv
// Two-way round-robin pick, purely combinational (zero latency, no backpressure).
// On a tie the requester not granted last wins; otherwise the single valid requester wins.
module rr_pick2
    import cache_port_arbiter_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_t last_grant,
    output req_id_t grant_id,
    output logic    grant_valid
);

    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = req_id_t'(0);
        if (valid0 && valid1) begin
            grant_id = ~last_grant;
        end else if (valid1) begin
            grant_id = req_id_t'(1);
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Arbitrates two requesters onto one cache port; accept at T, hit at T+1, response pulse at T+2.
// Both requesters see ready low while a request is in flight; a cache miss stalls in BUSY indefinitely.
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_rw,
    input  logic [DATA_W-1:0] req0_din,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_dout,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_rw,
    input  logic [DATA_W-1:0] req1_din,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_dout,

    output logic              cache_is_input_valid,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_mem_rw,
    output logic [DATA_W-1:0] cache_din,
    input  logic              cache_is_ready,
    input  logic              cache_is_output_valid,
    input  logic [DATA_W-1:0] cache_dout,

    output logic [31:0]       busy_cycles
);

    state_t  state;
    req_id_t last_grant;
    req_id_t owner;
    req_id_t grant_id;
    logic    grant_valid;
    logic    accept;
    logic    done;

    rr_pick2 u_rr_pick2 (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Ready is gated by reset so it drops the instant reset rises, not at the next edge.
    assign accept     = !reset && (state == IDLE) && grant_valid;
    assign req0_ready = accept && (grant_id == req_id_t'(0));
    assign req1_ready = accept && (grant_id == req_id_t'(1));
    assign done       = cache_is_output_valid && cache_is_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            last_grant           <= req_id_t'(1);
            owner                <= req_id_t'(0);
            cache_is_input_valid <= 1'b0;
            cache_addr           <= '0;
            cache_mem_rw         <= 1'b0;
            cache_din            <= '0;
            resp0_valid          <= 1'b0;
            resp1_valid          <= 1'b0;
            resp0_dout           <= '0;
            resp1_dout           <= '0;
            busy_cycles          <= '0;
        end else begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            if (state == IDLE) begin
                if (grant_valid) begin
                    owner                <= grant_id;
                    cache_addr           <= (grant_id == req_id_t'(1)) ? req1_addr : req0_addr;
                    cache_mem_rw         <= (grant_id == req_id_t'(1)) ? req1_rw   : req0_rw;
                    cache_din            <= (grant_id == req_id_t'(1)) ? req1_din  : req0_din;
                    cache_is_input_valid <= 1'b1;
                    state                <= BUSY;
                end
            end else begin
                busy_cycles <= busy_cycles + 32'd1;
                if (done) begin
                    cache_is_input_valid <= 1'b0;
                    last_grant           <= owner;
                    state                <= IDLE;
                    if (owner == req_id_t'(1)) begin
                        resp1_valid <= 1'b1;
                        resp1_dout  <= cache_dout;
                    end else begin
                        resp0_valid <= 1'b1;
                        resp0_dout  <= cache_dout;
                    end
                end
            end
        end
    end

endmodule

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning request address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning request and response word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports reqN_valid  input  1  requester N (N=0,1) presents a request.
REQ-006 SHALL have ports reqN_addr  input  ADDR_W, reqN_rw  input  1 (1=store), reqN_din  input  DATA_W  request payload.
REQ-007 SHALL have ports reqN_ready  output  1  request accepted this cycle.
REQ-008 SHALL have ports respN_valid  output  1  one-cycle completion pulse, and respN_dout  output  DATA_W  load data.
REQ-009 SHALL have cache-side outputs cache_is_input_valid (1), cache_addr (ADDR_W), cache_mem_rw (1) and cache_din (DATA_W).
REQ-010 SHALL have cache-side inputs cache_is_ready (1), cache_is_output_valid (1) and cache_dout (DATA_W).
REQ-011 SHALL have output busy_cycles  output  32  count of cycles spent in BUSY.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-013 In IDLE with at least one reqN_valid, SHALL grant one requester, latch its addr/rw/din, assert that reqN_ready for that cycle only, and go to BUSY.
REQ-014 When both requesters are valid in IDLE, SHALL grant the requester not granted last (round-robin); last_grant resets to 1, so req0 wins the first tie.
REQ-015 SHALL hold reqN_ready low for both requesters whenever the FSM is in BUSY, and in IDLE for every requester not granted.
REQ-016 In BUSY, SHALL drive cache_is_input_valid=1 with the latched addr/rw/din held stable until completion.
REQ-017 Completion is the cycle in BUSY where cache_is_output_valid=1 and cache_is_ready=1.
REQ-018 On completion, SHALL register cache_dout into respN_dout, pulse respN_valid of the granted requester for exactly the next cycle, update last_grant and return to IDLE.
REQ-019 Minimum latency SHALL be: accept at cycle T, hit at T+1, respN_valid at T+2; a cache miss extends BUSY by the miss penalty with no upper bound.
REQ-020 Back-to-back throughput SHALL be one request per 2 cycles; a new grant is allowed in the same cycle respN_valid is high.
REQ-021 For stores, respN_dout is unspecified; only respN_valid is meaningful.
REQ-022 A requester deasserting reqN_valid before acceptance SHALL have no effect; after acceptance, input changes SHALL be ignored.
REQ-023 In IDLE, cache_is_input_valid SHALL be 0, and cache_addr/cache_mem_rw/cache_din SHALL hold their last values.
REQ-024 busy_cycles SHALL increment by 1 in every BUSY cycle and wrap modulo 2^32.

Reset
REQ-025 Asserting reset SHALL immediately, without waiting for clk, force IDLE, last_grant=1 and busy_cycles=0, drive all ready/valid outputs to 0, and set cache_addr, cache_din, cache_mem_rw and respN_dout to 0.
REQ-026 On a reset mid-BUSY, SHALL abandon the in-flight request with no respN_valid; the cache is reset by the same signal.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=1'b0, BUSY=1'b1) and the requester-id width constant.
REQ-028 The two-way round-robin pick SHALL be a combinational sub-module named rr_pick2, taking the two valids and last_grant and returning a grant id and a grant-valid flag.

Verification
REQ-029 Scenario: req0 load addr=0x40 with the cache hitting on the first BUSY cycle -> req0_ready at T, cache_is_input_valid at T+1, resp0_valid at T+2 with resp0_dout=cache_dout.
REQ-030 Scenario: req0 and req1 both valid from reset -> grant order 0,1,0,1 across 4 requests, each resp pulse exactly 1 cycle.
REQ-031 Scenario: req1 store addr=0x80 din=0xDEADBEEF with cache_is_ready low for 20 cycles (miss) -> cache inputs stable for all 21 BUSY cycles, resp1_valid once, busy_cycles=21.
REQ-032 Scenario: req0 changes addr to 0x44 one cycle after acceptance -> cache_addr stays 0x40.
REQ-033 Scenario: reset asserted mid-BUSY between clock edges -> cache_is_input_valid falls before the next edge, no respN_valid, first post-reset tie granted to req0.
